// File: rtl/sparse_chunk_writer_if.sv
// Chunk-write bus between a dense byte source, the sparse chunk writer and the chunk-buffer consumer.
// The writer uses the slave modport; the source/consumer side uses master.
interface sparse_chunk_writer_if #(
  parameter int BUS_SIZE         = 16,
  parameter int WR_DAT_CYC_NUM   = 4,
  parameter int COMPUTE_UNIT_NUM = 4
);
  localparam int CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int CU_W  = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1;

  logic                        dense_valid_i;
  logic                        dense_ready_o;
  logic [BUS_SIZE*8-1:0]       dense_data_i;
  logic [CU_W-1:0]             cu_dst_i;
  logic                        cu_bcast_i;
  logic                        rd_done_i;
  logic [BUS_SIZE-1:0]         wr_sparsemap_o;
  logic [BUS_SIZE*8-1:0]       wr_nonzero_data_o;
  logic                        wr_valid_o;
  logic [CNT_W-1:0]            wr_count_o;
  logic                        wr_sel_o;
  logic [COMPUTE_UNIT_NUM-1:0] cu_wr_sel_o;
  logic                        rd_sel_o;
  logic                        chunk_avail_o;

  modport master (
    output dense_valid_i, dense_data_i, cu_dst_i, cu_bcast_i, rd_done_i,
    input  dense_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, wr_count_o,
           wr_sel_o, cu_wr_sel_o, rd_sel_o, chunk_avail_o
  );

  modport slave (
    input  dense_valid_i, dense_data_i, cu_dst_i, cu_bcast_i, rd_done_i,
    output dense_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, wr_count_o,
           wr_sel_o, cu_wr_sel_o, rd_sel_o, chunk_avail_o
  );
endinterface

// File: rtl/sparse_chunk_writer.sv
// Compacts dense byte beats into sparsemap + packed nonzero bytes and writes them into
// ping-pong chunk buffers, stalling the source while the target buffer is still unread.
module sparse_chunk_writer #(
  parameter int BUS_SIZE         = 16,
  parameter int WR_DAT_CYC_NUM   = 4,
  parameter int COMPUTE_UNIT_NUM = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sparse_chunk_writer_if.slave bus
);
  localparam int CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int CU_W  = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WR_DAT_CYC_NUM - 1);

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL} buf_state_t;

  buf_state_t                  buf_state_q [2];
  buf_state_t                  buf_state_d [2];
  logic                        wptr_q;
  logic                        rptr_q;
  logic [CNT_W-1:0]            beat_cnt_q;
  logic [CU_W-1:0]             dst_q;
  logic                        bcast_q;

  logic [1:0]                  full;
  logic                        accept;
  logic                        first_beat;
  logic                        last_beat;
  logic                        chunk_avail;
  logic                        read_ack;
  logic [BUS_SIZE-1:0]         sparsemap;
  logic [BUS_SIZE*8-1:0]       nz_data;
  int                          lane;
  logic [CU_W-1:0]             cur_dst;
  logic                        cur_bcast;
  logic [COMPUTE_UNIT_NUM-1:0] cu_mask;

  assign full[0]     = (buf_state_q[0] == BUF_FULL);
  assign full[1]     = (buf_state_q[1] == BUF_FULL);
  assign first_beat  = (beat_cnt_q == '0);
  assign last_beat   = (beat_cnt_q == LAST_BEAT);

  // Ready is held low while in reset so that every output reads 0 during reset.
  assign bus.dense_ready_o = rst_i & ~full[wptr_q];
  assign accept            = bus.dense_valid_i & bus.dense_ready_o;

  // A buffer whose final beat is still on the write bus is not yet readable.
  assign chunk_avail       = full[rptr_q] & ~(bus.wr_valid_o & (bus.wr_sel_o == rptr_q));
  assign read_ack          = bus.rd_done_i & chunk_avail;
  assign bus.chunk_avail_o = chunk_avail;
  assign bus.rd_sel_o      = rptr_q;

  always_comb begin
    sparsemap = '0;
    nz_data   = '0;
    lane      = 0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (bus.dense_data_i[8*k +: 8] != 8'h00) begin
        sparsemap[k]         = 1'b1;
        nz_data[8*lane +: 8] = bus.dense_data_i[8*k +: 8];
        lane                 = lane + 1;
      end
    end
  end

  // Beat 0 takes the destination straight from the inputs; later beats use the latched copy.
  always_comb begin
    cur_dst   = first_beat ? bus.cu_dst_i   : dst_q;
    cur_bcast = first_beat ? bus.cu_bcast_i : bcast_q;
    cu_mask   = cur_bcast ? '1 : (COMPUTE_UNIT_NUM'(1) << cur_dst);
  end

  always_comb begin
    buf_state_d = buf_state_q;
    if (accept) begin
      if (last_beat) begin
        buf_state_d[wptr_q] = BUF_FULL;
      end else if (first_beat) begin
        buf_state_d[wptr_q] = BUF_FILLING;
      end
    end
    if (read_ack) begin
      buf_state_d[rptr_q] = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_state_q[0] <= BUF_EMPTY;
      buf_state_q[1] <= BUF_EMPTY;
    end else begin
      buf_state_q <= buf_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q                <= 1'b0;
      rptr_q                <= 1'b0;
      beat_cnt_q            <= '0;
      dst_q                 <= '0;
      bcast_q               <= 1'b0;
      bus.wr_valid_o        <= 1'b0;
      bus.wr_sparsemap_o    <= '0;
      bus.wr_nonzero_data_o <= '0;
      bus.wr_count_o        <= '0;
      bus.wr_sel_o          <= 1'b0;
      bus.cu_wr_sel_o       <= '0;
    end else begin
      if (read_ack) begin
        rptr_q <= ~rptr_q;
      end
      bus.wr_valid_o <= accept;
      if (accept) begin
        bus.wr_sparsemap_o    <= sparsemap;
        bus.wr_nonzero_data_o <= nz_data;
        bus.wr_count_o        <= beat_cnt_q;
        bus.wr_sel_o          <= wptr_q;
        bus.cu_wr_sel_o       <= cu_mask;
        beat_cnt_q            <= last_beat ? '0 : beat_cnt_q + 1'b1;
        if (first_beat) begin
          dst_q   <= bus.cu_dst_i;
          bcast_q <= bus.cu_bcast_i;
        end
        if (last_beat) begin
          wptr_q <= ~wptr_q;
        end
      end else begin
        bus.wr_sparsemap_o    <= '0;
        bus.wr_nonzero_data_o <= '0;
        bus.wr_count_o        <= '0;
        bus.wr_sel_o          <= 1'b0;
        bus.cu_wr_sel_o       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Directed bench for sparse_chunk_writer: table-driven compaction/chunk vectors plus
// hand-written backpressure, reset, CU-select and simultaneous-event sequences.
module tb_sparse_chunk_writer;
  localparam int BUS_SIZE = 16;
  localparam int WR_NUM   = 4;
  localparam int CU_NUM   = 4;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   dst;
    logic         bcast;
    logic [15:0]  exp_map;
    logic [127:0] exp_nz;
    logic [3:0]   exp_cu;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic acc;
  vec_t vecs [8];

  always #5 clk_i = ~clk_i;

  sparse_chunk_writer_if #(.BUS_SIZE(BUS_SIZE), .WR_DAT_CYC_NUM(WR_NUM), .COMPUTE_UNIT_NUM(CU_NUM)) bus ();

  sparse_chunk_writer #(.BUS_SIZE(BUS_SIZE), .WR_DAT_CYC_NUM(WR_NUM), .COMPUTE_UNIT_NUM(CU_NUM)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [127:0] data, input logic [1:0] dst,
                                input logic bcast, input logic rd_done);
    bus.dense_valid_i = valid;
    bus.dense_data_i  = data;
    bus.cu_dst_i      = dst;
    bus.cu_bcast_i    = bcast;
    bus.rd_done_i     = rd_done;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_ready"}, bus.dense_ready_o, 1'b0);
    check_bit({tag, "_wr_valid"}, bus.wr_valid_o, 1'b0);
    check_output({tag, "_map"}, 128'(bus.wr_sparsemap_o), 128'(0));
    check_output({tag, "_nz"}, bus.wr_nonzero_data_o, 128'(0));
    check_output({tag, "_count"}, 128'(bus.wr_count_o), 128'(0));
    check_bit({tag, "_wr_sel"}, bus.wr_sel_o, 1'b0);
    check_output({tag, "_cu"}, 128'(bus.cu_wr_sel_o), 128'(0));
    check_bit({tag, "_rd_sel"}, bus.rd_sel_o, 1'b0);
    check_bit({tag, "_avail"}, bus.chunk_avail_o, 1'b0);
  endtask

  // Offers one beat from a negedge, waits (bounded) for ready, returns #1 after the accepting edge.
  task automatic send_beat(input logic [127:0] data, input logic [1:0] dst, input logic bcast,
                           output logic accepted);
    @(negedge clk_i);
    apply_stimulus(1'b1, data, dst, bcast, 1'b0);
    accepted = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.dense_ready_o) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (accepted) begin
      @(posedge clk_i);
      #1;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready=0 for 20 cycles, expected ready=1");
    end
    bus.dense_valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    apply_stimulus(1'b0, '0, 2'd0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{128'h0, 2'd3, 1'b0, 16'h0000, 128'h0, 4'b1000};
    vecs[1] = '{128'h07000500, 2'd0, 1'b0, 16'h000A, 128'h0705, 4'b1000};
    vecs[2] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 16'hFFFF,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[3] = '{128'h11000000_00000000_00000000_00000000, 2'd2, 1'b0, 16'h8000, 128'h11, 4'b1000};
    vecs[4] = '{128'h000000AB, 2'd0, 1'b1, 16'h0001, 128'hAB, 4'b1111};
    vecs[5] = '{128'h01000200_00000300_04000000_00000005, 2'd3, 1'b0, 16'hA281, 128'h0102030405, 4'b1111};
    vecs[6] = '{128'h80808080_00000000_00000000_00000000, 2'd1, 1'b0, 16'hF000, 128'h80808080, 4'b1111};
    vecs[7] = '{128'h00000000_000000A5_00000000_00000000, 2'd2, 1'b0, 16'h0100, 128'hA5, 4'b1111};

    apply_stimulus(1'b0, '0, 2'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_bit("post_reset_ready", bus.dense_ready_o, 1'b1);

    // Two back-to-back chunks fill both buffers.
    for (int i = 0; i < 8; i++) begin
      send_beat(vecs[i].data, vecs[i].dst, vecs[i].bcast, acc);
      check_output($sformatf("v%0d_map", i), 128'(bus.wr_sparsemap_o), 128'(vecs[i].exp_map));
      check_output($sformatf("v%0d_nz", i), bus.wr_nonzero_data_o, vecs[i].exp_nz);
      check_bit($sformatf("v%0d_wr_valid", i), bus.wr_valid_o, 1'b1);
      check_output($sformatf("v%0d_count", i), 128'(bus.wr_count_o), 128'(i % 4));
      check_bit($sformatf("v%0d_wr_sel", i), bus.wr_sel_o, (i >= 4));
      check_output($sformatf("v%0d_cu", i), 128'(bus.cu_wr_sel_o), 128'(vecs[i].exp_cu));
      if (i == 3) check_bit("avail_masked_beat3", bus.chunk_avail_o, 1'b0);
      if (i == 4) begin
        check_bit("avail_after_chunk0", bus.chunk_avail_o, 1'b1);
        check_bit("rd_sel_after_chunk0", bus.rd_sel_o, 1'b0);
      end
    end
    idle_cycle();
    check_bit("both_full_wr_valid", bus.wr_valid_o, 1'b0);
    check_bit("both_full_ready", bus.dense_ready_o, 1'b0);
    check_bit("both_full_avail", bus.chunk_avail_o, 1'b1);

    // Ninth beat is held until buffer 0 is released.
    @(negedge clk_i);
    apply_stimulus(1'b1, 128'h42, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_bit($sformatf("stall%0d_ready", k), bus.dense_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
      check_bit($sformatf("stall%0d_wr_valid", k), bus.wr_valid_o, 1'b0);
      @(negedge clk_i);
    end
    bus.rd_done_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rd_done_i = 1'b0;
    check_bit("rd_done_ready", bus.dense_ready_o, 1'b1);
    check_bit("rd_done_rd_sel", bus.rd_sel_o, 1'b1);
    check_bit("rd_done_avail", bus.chunk_avail_o, 1'b1);
    check_bit("rd_done_wr_valid", bus.wr_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    bus.dense_valid_i = 1'b0;
    check_bit("beat9_wr_valid", bus.wr_valid_o, 1'b1);
    check_output("beat9_count", 128'(bus.wr_count_o), 128'(0));
    check_bit("beat9_wr_sel", bus.wr_sel_o, 1'b0);
    check_output("beat9_map", 128'(bus.wr_sparsemap_o), 128'h1);
    check_output("beat9_nz", bus.wr_nonzero_data_o, 128'h42);
    check_output("beat9_cu", 128'(bus.cu_wr_sel_o), 128'(4'b0010));

    // Reset after beat 1 discards the partial chunk.
    send_beat(128'h0100, 2'd0, 1'b0, acc);
    check_output("pre_rst_count", 128'(bus.wr_count_o), 128'(1));
    rst_i = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Destination latched on beat 0; mid-chunk change ignored.
    for (int b = 0; b < 4; b++) begin
      send_beat(128'(b + 1), (b < 2) ? 2'd2 : 2'd1, 1'b0, acc);
      check_output($sformatf("cu_b%0d", b), 128'(bus.cu_wr_sel_o), 128'(4'b0100));
      check_output($sformatf("cu_b%0d_count", b), 128'(bus.wr_count_o), 128'(b));
      check_bit($sformatf("cu_b%0d_wr_sel", b), bus.wr_sel_o, 1'b0);
    end

    // Buffer 1 last beat coincides with rd_done for buffer 0.
    for (int b = 0; b < 3; b++) begin
      send_beat(128'h5, 2'd0, 1'b1, acc);
      check_bit($sformatf("buf1_b%0d_wr_sel", b), bus.wr_sel_o, 1'b1);
    end
    @(negedge clk_i);
    apply_stimulus(1'b1, 128'h9, 2'd0, 1'b0, 1'b1);
    check_bit("sim_pre_ready", bus.dense_ready_o, 1'b1);
    check_bit("sim_pre_avail", bus.chunk_avail_o, 1'b1);
    @(posedge clk_i);
    #1;
    bus.dense_valid_i = 1'b0;
    bus.rd_done_i     = 1'b0;
    check_bit("sim_wr_valid", bus.wr_valid_o, 1'b1);
    check_bit("sim_wr_sel", bus.wr_sel_o, 1'b1);
    check_output("sim_count", 128'(bus.wr_count_o), 128'(3));
    check_output("sim_cu", 128'(bus.cu_wr_sel_o), 128'(4'b1111));
    check_bit("sim_rd_sel", bus.rd_sel_o, 1'b1);
    check_bit("sim_avail_masked", bus.chunk_avail_o, 1'b0);
    check_bit("sim_ready", bus.dense_ready_o, 1'b1);
    idle_cycle();
    check_bit("sim_next_avail", bus.chunk_avail_o, 1'b1);
    check_bit("sim_next_wr_valid", bus.wr_valid_o, 1'b0);

    // Release buffer 1, then an rd_done with nothing available must be ignored.
    @(negedge clk_i);
    bus.rd_done_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rd_done_i = 1'b0;
    check_bit("drain_rd_sel", bus.rd_sel_o, 1'b0);
    check_bit("drain_avail", bus.chunk_avail_o, 1'b0);
    @(negedge clk_i);
    bus.rd_done_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rd_done_i = 1'b0;
    check_bit("ignored_rd_done_rd_sel", bus.rd_sel_o, 1'b0);
    check_bit("ignored_rd_done_ready", bus.dense_ready_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
